// File: rtl/ecc_csr_bank_if.sv
// Host register-bus bundle for ecc_csr_bank: write/read strobes, address,
// byte-enabled write data and the registered read-data return path.
interface ecc_csr_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                Load;
  logic                Read;
  logic [ADDR_W-1:0]   ADDR;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W/8-1:0] AVL_BYTE_EN;
  logic [DATA_W-1:0]   Data_Out;
  logic                rd_valid;

  modport master (
    output Load, Read, ADDR, write_data, AVL_BYTE_EN,
    input  Data_Out, rd_valid
  );

  modport slave (
    input  Load, Read, ADDR, write_data, AVL_BYTE_EN,
    output Data_Out, rd_valid
  );
endinterface

// File: rtl/ecc_csr_bank.sv
// CSR bank fronting an ECC core: writable message words, read-only key words,
// CTRL/STATUS at the top two addresses. Optional irq output via ECC_CSR_IRQ_EN.
module ecc_csr_bank #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MSG_WORDS = 8,
  parameter int KEY_WORDS = 8
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  ecc_csr_bank_if.slave                 bus,
  output logic [MSG_WORDS*DATA_W-1:0]   msg_out,
  output logic                          start,
  input  logic [KEY_WORDS*DATA_W-1:0]   key_in,
  input  logic                          core_done,
  output logic                          busy
`ifdef ECC_CSR_IRQ_EN
  ,output logic                         irq
`endif
);

  localparam int LANES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] STAT_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] msg_q [MSG_WORDS];
  logic [DATA_W-1:0] key_q [KEY_WORDS];
  logic              err_q, err_d;
  logic              start_d;
  logic [DATA_W-1:0] rd_mux;

  logic lane0_wr, ctrl_go, stat_clr_done, stat_clr_err;
  logic msg_hit, msg_touch, msg_wr, take_done;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [LANES-1:0]  be
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < LANES; b++)
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    return res;
  endfunction

  assign lane0_wr      = bus.Load && bus.AVL_BYTE_EN[0];
  assign ctrl_go       = lane0_wr && (bus.ADDR == CTRL_ADDR) && bus.write_data[0];
  assign stat_clr_done = lane0_wr && (bus.ADDR == STAT_ADDR) && bus.write_data[0];
  assign stat_clr_err  = lane0_wr && (bus.ADDR == STAT_ADDR) && bus.write_data[1];
  assign msg_hit       = int'(bus.ADDR) < MSG_WORDS;
  assign msg_touch     = bus.Load && msg_hit && (|bus.AVL_BYTE_EN);
  assign msg_wr        = bus.Load && (state_q != BUSY);
  assign take_done     = (state_q == BUSY) && core_done;
  assign busy          = (state_q == BUSY);

  // Next-state and sticky-error logic; core_done wins over a coincident start.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    err_d   = err_q;
    if (stat_clr_err) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_go) begin
          state_d = BUSY;
          start_d = 1'b1;
        end
      end
      BUSY: begin
        if (core_done) state_d = DONE;
        if (ctrl_go || msg_touch) err_d = 1'b1;
      end
      DONE: begin
        if (ctrl_go) begin
          state_d = BUSY;
          start_d = 1'b1;
        end else if (stat_clr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      start   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start   <= start_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < MSG_WORDS; i++) msg_q[i] <= '0;
    end else begin
      for (int i = 0; i < MSG_WORDS; i++)
        if (msg_wr && (int'(bus.ADDR) == i))
          msg_q[i] <= merge_lanes(msg_q[i], bus.write_data, bus.AVL_BYTE_EN);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
    end else if (take_done) begin
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= key_in[i*DATA_W +: DATA_W];
    end
  end

  // Read mux sees pre-edge register contents, so same-cycle writes are not visible.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < MSG_WORDS; i++)
      if (int'(bus.ADDR) == i) rd_mux = msg_q[i];
    for (int i = 0; i < KEY_WORDS; i++)
      if (int'(bus.ADDR) == MSG_WORDS + i) rd_mux = key_q[i];
    if (bus.ADDR == STAT_ADDR) rd_mux[2:0] = {err_q, busy, state_q == DONE};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.Data_Out <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.Read;
      if (bus.Read) bus.Data_Out <= rd_mux;
    end
  end

  for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg_out
    assign msg_out[g*DATA_W +: DATA_W] = msg_q[g];
  end

`ifdef ECC_CSR_IRQ_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) irq <= 1'b0;
    else          irq <= (state_d == DONE);
  end
`endif

endmodule

// File: tb/tb_ecc_csr_bank.sv
// Directed testbench for ecc_csr_bank with a spec-level reference model and
// a per-cycle compare process; irq is checked when ECC_CSR_IRQ_EN is defined.
module tb_ecc_csr_bank;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 8;
  localparam int KW = 8;
  localparam logic [AW-1:0] CTRL = 5'd30;
  localparam logic [AW-1:0] STAT = 5'd31;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b1;
  logic [MW*DW-1:0] msg_out;
  logic            start;
  logic [KW*DW-1:0] key_in = '0;
  logic            core_done = 1'b0;
  logic            busy;
`ifdef ECC_CSR_IRQ_EN
  logic            irq;
`endif

  int nCompared = 0;
  int nMismatched = 0;
  bit started = 1'b0;

  ecc_csr_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ecc_csr_bank #(.DATA_W(DW), .ADDR_W(AW), .MSG_WORDS(MW), .KEY_WORDS(KW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave), .msg_out(msg_out),
    .start(start), .key_in(key_in), .core_done(core_done), .busy(busy)
`ifdef ECC_CSR_IRQ_EN
    ,.irq(irq)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model: register file as arrays plus busy/done/err flags.
  logic [DW-1:0] mMsg [MW];
  logic [DW-1:0] mKey [KW];
  logic mBusy, mDone, mErr, mStart, mRdValid;
  logic [DW-1:0] mDout;

  function automatic logic [DW-1:0] modelRead(input int a);
    if (a < MW) return mMsg[a];
    if (a < MW + KW) return mKey[a - MW];
    if (a == 31) return {29'd0, mErr, mBusy, mDone};
    return '0;
  endfunction

  function automatic logic [DW-1:0] byteMask(input logic [3:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < MW; i++) mMsg[i] <= '0;
      for (int i = 0; i < KW; i++) mKey[i] <= '0;
      {mBusy, mDone, mErr, mStart, mRdValid} <= '0;
      mDout <= '0;
    end else begin
      mRdValid <= bus.Read;
      if (bus.Read) mDout <= modelRead(int'(bus.ADDR));
      mStart <= 1'b0;
      if (bus.Load) begin
        if (int'(bus.ADDR) < MW) begin
          if (mBusy) begin
            if (bus.AVL_BYTE_EN != 4'b0) mErr <= 1'b1;
          end else begin
            mMsg[int'(bus.ADDR)] <= (mMsg[int'(bus.ADDR)] & ~byteMask(bus.AVL_BYTE_EN))
                                  | (bus.write_data & byteMask(bus.AVL_BYTE_EN));
          end
        end else if (bus.ADDR == CTRL && bus.AVL_BYTE_EN[0] && bus.write_data[0]) begin
          if (mBusy) mErr <= 1'b1;
          else begin
            mStart <= 1'b1;
            mBusy  <= 1'b1;
            mDone  <= 1'b0;
          end
        end else if (bus.ADDR == STAT && bus.AVL_BYTE_EN[0]) begin
          if (bus.write_data[1]) mErr <= 1'b0;
          if (bus.write_data[0] && mDone) mDone <= 1'b0;
        end
      end
      if (core_done && mBusy) begin
        for (int i = 0; i < KW; i++) mKey[i] <= key_in[i*DW +: DW];
        mBusy <= 1'b0;
        mDone <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (started && Reset_n) begin
      checkOutput("cyc_rd_valid", {31'd0, bus.rd_valid}, {31'd0, mRdValid});
      checkOutput("cyc_data_out", bus.Data_Out, mDout);
      checkOutput("cyc_busy", {31'd0, busy}, {31'd0, mBusy});
      checkOutput("cyc_start", {31'd0, start}, {31'd0, mStart});
      for (int i = 0; i < MW; i++)
        checkOutput("cyc_msg_out", msg_out[i*DW +: DW], mMsg[i]);
`ifdef ECC_CSR_IRQ_EN
      checkOutput("cyc_irq", {31'd0, irq}, {31'd0, mDone});
`endif
    end
  end

  task automatic applyStimulus(input logic ld, input logic rd, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [3:0] be, input logic cd);
    @(negedge Clk);
    #1;
    bus.Load = ld;
    bus.Read = rd;
    bus.ADDR = a;
    bus.write_data = d;
    bus.AVL_BYTE_EN = be;
    core_done = cd;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
  endtask

  task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    applyStimulus(1'b1, 1'b0, a, d, be, 1'b0);
    idleCycle();
  endtask

  task automatic readWord(input logic [AW-1:0] a, output logic [DW-1:0] d);
    applyStimulus(1'b0, 1'b1, a, '0, 4'h0, 1'b0);
    idleCycle();
    d = bus.Data_Out;
  endtask

  logic [DW-1:0] rd;

  initial begin
    bus.Load = 1'b0; bus.Read = 1'b0; bus.ADDR = '0;
    bus.write_data = '0; bus.AVL_BYTE_EN = '0;
    #2 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("rst_data_out", bus.Data_Out, 32'h0);
    checkOutput("rst_rd_valid", {31'd0, bus.rd_valid}, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'h0);
    checkOutput("rst_start", {31'd0, start}, 32'h0);
    #1 Reset_n = 1'b1;
    started = 1'b1;

    // Byte-lane writes, unmapped access, CTRL read
    writeWord(5'd3, 32'hDEADBEEF, 4'b1010);
    readWord(5'd3, rd);                  checkOutput("be_1010", rd, 32'hDE00BE00);
    writeWord(5'd1, 32'hCAFEF00D, 4'hF);
    writeWord(5'd1, 32'hFFFFFFFF, 4'h0);
    readWord(5'd1, rd);                  checkOutput("be_none", rd, 32'hCAFEF00D);
    writeWord(5'd20, 32'h12341234, 4'hF);
    readWord(5'd20, rd);                 checkOutput("unmapped", rd, 32'h0);
    readWord(CTRL, rd);                  checkOutput("ctrl_read", rd, 32'h0);

    // Same-cycle read and write returns old value
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h11111111, 4'hF, 1'b0);
    idleCycle();
    checkOutput("rw_same_old", bus.Data_Out, 32'hDE00BE00);
    readWord(5'd3, rd);                  checkOutput("rw_same_new", rd, 32'h11111111);

    // Start the core
    writeWord(CTRL, 32'h1, 4'h1);
    checkOutput("start_pulse", {31'd0, start}, 32'h1);
    checkOutput("busy_set", {31'd0, busy}, 32'h1);
    idleCycle();
    checkOutput("start_once", {31'd0, start}, 32'h0);
    writeWord(5'd0, 32'h55, 4'hF);
    readWord(5'd0, rd);                  checkOutput("busy_msg_ign", rd, 32'h0);
    readWord(STAT, rd);                  checkOutput("stat_busy_err", rd, 32'h6);

    // Core completion
    key_in = '0;
    key_in[31:0] = 32'h12345678;
    for (int k = 1; k < KW; k++) key_in[k*DW +: DW] = 32'hA0000000 + k;
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1);
    idleCycle();
    writeWord(STAT, 32'h2, 4'h1);
    readWord(STAT, rd);                  checkOutput("stat_done", rd, 32'h1);
    readWord(5'd8, rd);                  checkOutput("key0", rd, 32'h12345678);
    readWord(5'd15, rd);                 checkOutput("key7", rd, 32'hA0000007);
`ifdef ECC_CSR_IRQ_EN
    checkOutput("irq_set", {31'd0, irq}, 32'h1);
`endif

    // Acknowledge, key read-only, stray core_done
    writeWord(STAT, 32'h1, 4'h1);
    readWord(STAT, rd);                  checkOutput("stat_idle", rd, 32'h0);
`ifdef ECC_CSR_IRQ_EN
    checkOutput("irq_clr", {31'd0, irq}, 32'h0);
`endif
    writeWord(5'd8, 32'hFFFFFFFF, 4'hF);
    readWord(5'd8, rd);                  checkOutput("key_ro", rd, 32'h12345678);
    key_in[31:0] = 32'hBAD0BAD0;
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1);
    idleCycle();
    readWord(5'd8, rd);                  checkOutput("stray_done", rd, 32'h12345678);

    // Start write coinciding with core_done
    writeWord(CTRL, 32'h1, 4'h1);
    applyStimulus(1'b1, 1'b0, CTRL, 32'h1, 4'h1, 1'b1);
    idleCycle();
    checkOutput("coinc_nostart", {31'd0, start}, 32'h0);
    readWord(STAT, rd);                  checkOutput("coinc_stat", rd, 32'h5);
    readWord(5'd8, rd);                  checkOutput("coinc_key", rd, 32'hBAD0BAD0);

    // Reset mid-BUSY
    writeWord(STAT, 32'h3, 4'h1);
    readWord(STAT, rd);                  checkOutput("clr_both", rd, 32'h0);
    writeWord(CTRL, 32'h1, 4'h1);
    @(negedge Clk);
    #3 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    #1 Reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1);
    idleCycle();
    checkOutput("rst_busy_clr", {31'd0, busy}, 32'h0);
    readWord(5'd8, rd);                  checkOutput("rst_key0", rd, 32'h0);
    readWord(5'd15, rd);                 checkOutput("rst_key7", rd, 32'h0);
    readWord(STAT, rd);                  checkOutput("rst_stat", rd, 32'h0);
    readWord(5'd3, rd);                  checkOutput("rst_msg3", rd, 32'h0);

    idleCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
